alu_button_conditioner: RTL and testbench

//  Front-panel input stage directly upstream of the ALU operations block.

---
 rtl/alu_button_conditioner_pkg.sv | 34 +++
 rtl/alu_button_conditioner_if.sv | 39 +++
 rtl/alu_button_conditioner_debounce_channel.sv | 119 +++++++++++
 rtl/alu_button_conditioner.sv | 100 ++++++++++
 tb/tb_alu_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_button_conditioner_pkg.sv
//==============================================================================
// Module : alu_ui_pkg
// Brief  : Shared constants for the ALU front-panel conditioner. It holds the
//          debounce FSM state encoding, the switch-bank field positions and the
//          default debounce length for the 100 MHz board.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package alu_ui_pkg;

  typedef logic [1:0] db_state_t;

  // The level-high states are exactly the ones with bit 1 set.
  localparam db_state_t S_LO      = 2'd0;
  localparam db_state_t S_WAIT_HI = 2'd1;
  localparam db_state_t S_HI      = 2'd2;
  localparam db_state_t S_WAIT_LO = 2'd3;

  localparam int SW_W        = 12;
  localparam int SW_OP_MSB   = 11;
  localparam int SW_OP_LSB   = 8;
  localparam int SW_DATA_MSB = 7;
  localparam int SW_DATA_LSB = 0;
  localparam int OP_W        = SW_OP_MSB - SW_OP_LSB + 1;
  localparam int DATA_W      = SW_DATA_MSB - SW_DATA_LSB + 1;

  // 10 ms at 100 MHz.
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/alu_button_conditioner_if.sv
//==============================================================================
// Module : alu_button_conditioner_if
// Brief  : Bundle connecting the front panel to the ALU through the
//          conditioner.
//          Raw side : btn_action_raw, btn_reset_raw, sw_raw[11:0]
//          ALU side : do_action, alu_reset, op_addr[3:0], data_in[7:0],
//                     btn_level[1:0] = {reset, action}
//          The master modport is the panel/ALU environment. The slave modport
//          is the conditioner.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface alu_button_conditioner_if;
  import alu_ui_pkg::*;

  logic              btn_action_raw;
  logic              btn_reset_raw;
  logic [SW_W-1:0]   sw_raw;
  logic              do_action;
  logic              alu_reset;
  logic [OP_W-1:0]   op_addr;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        btn_level;

  modport master (
    output btn_action_raw, btn_reset_raw, sw_raw,
    input  do_action, alu_reset, op_addr, data_in, btn_level
  );

  modport slave (
    input  btn_action_raw, btn_reset_raw, sw_raw,
    output do_action, alu_reset, op_addr, data_in, btn_level
  );

endinterface

`default_nettype wire

// File: rtl/alu_button_conditioner_debounce_channel.sv
//==============================================================================
// Module : debounce_channel
// Brief  : Debounces one asynchronous button. It uses a two-flop synchronizer,
//          then a four-state accept FSM with a saturating sample counter.
//          clk, reset_n : clock and asynchronous active-low reset
//          raw          : raw bouncy button input
//          level        : debounced level (registered state bit)
//          rise / fall  : high during the cycle whose closing edge changes level
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module debounce_channel
  import alu_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_q1;
  logic             sync_q2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter holds at its terminal value and never wraps.
  assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_LO: begin
        if (sync_q2) begin
          state_nxt = S_WAIT_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_WAIT_HI: begin
        if (!sync_q2) begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      S_HI: begin
        if (!sync_q2) begin
          state_nxt = S_WAIT_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LO: begin
        if (sync_q2) begin
          state_nxt = S_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end
      default: begin
        state_nxt = S_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    level = state[1];
    rise  = (state == S_WAIT_HI) && sync_q2  && (cnt == CNT_LAST);
    fall  = (state == S_WAIT_LO) && !sync_q2 && (cnt == CNT_LAST);
  end

endmodule

`default_nettype wire

// File: rtl/alu_button_conditioner.sv
//==============================================================================
// Module : alu_button_conditioner
// Brief  : Front-panel input stage for the ALU. It debounces BtnC (action) and
//          BtnU (reset), synchronizes the switches and captures the
//          opcode/data on an accepted press. It then issues a one-cycle
//          do_action strobe one clock after the capture.
//          clk, reset_n : clock and asynchronous active-low reset
//          bus (slave)  : raw panel inputs in; do_action, alu_reset, op_addr,
//                         data_in and btn_level out
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_button_conditioner
  import alu_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  alu_button_conditioner_if.slave  bus
);

  logic              action_level;
  logic              action_rise;
  logic              action_fall;
  logic              reset_level;
  logic              reset_rise;
  logic              reset_fall;
  logic              unused_falls;
  logic              accept;
  logic              action_pend;
  logic              do_action_q;
  logic [SW_W-1:0]   sw_q1;
  logic [SW_W-1:0]   sw_q2;
  logic [OP_W-1:0]   op_addr_q;
  logic [DATA_W-1:0] data_in_q;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_action (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.btn_action_raw),
    .level   (action_level),
    .rise    (action_rise),
    .fall    (action_fall)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (bus.btn_reset_raw),
    .level   (reset_level),
    .rise    (reset_rise),
    .fall    (reset_fall)
  );

  assign unused_falls = action_fall ^ reset_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= bus.sw_raw;
      sw_q2 <= sw_q1;
    end
  end

  // A reset level, or a reset accepted on the same edge, suppresses the press.
  assign accept = action_rise && !reset_level && !reset_rise;

  // The operands land on the accept edge, and do_action follows one edge later.
  // This keeps the ALU inputs settled before the strobe. An async reset
  // between the two edges clears action_pend, which drops the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_addr_q   <= '0;
      data_in_q   <= '0;
      action_pend <= 1'b0;
      do_action_q <= 1'b0;
    end else begin
      if (accept) begin
        op_addr_q <= sw_q2[SW_OP_MSB:SW_OP_LSB];
        data_in_q <= sw_q2[SW_DATA_MSB:SW_DATA_LSB];
      end
      action_pend <= accept;
      do_action_q <= action_pend;
    end
  end

  assign bus.do_action = do_action_q;
  assign bus.alu_reset = reset_level;
  assign bus.op_addr   = op_addr_q;
  assign bus.data_in   = data_in_q;
  assign bus.btn_level = {reset_level, action_level};

endmodule

`default_nettype wire

// File: tb/tb_alu_button_conditioner.sv
//==============================================================================
// Module : tb_alu_button_conditioner
// Brief  : Scoreboard bench for alu_button_conditioner with DEBOUNCE_CYCLES=4.
//          A window-based reference model predicts levels, captures and strobes.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_button_conditioner;
  import alu_ui_pkg::*;

  localparam int D = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  alu_button_conditioner_if bus();

  alu_button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int cycle      = 0;
  int dut_pulses = 0;

  typedef struct {
    int         due;
    logic [3:0] op;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: a level flips once the last D synchronized samples all
  // disagree with it. Synchronization is modelled as a two-sample delay.
  logic        m_a_p0 = 0, m_a_p1 = 0, m_r_p0 = 0, m_r_p1 = 0;
  logic [11:0] m_sw_p0 = '0, m_sw_p1 = '0;
  bit          m_a_hist[$];
  bit          m_r_hist[$];
  logic        m_a_lvl = 0, m_r_lvl = 0;
  logic [3:0]  m_op = '0;
  logic [7:0]  m_data = '0;

  function automatic bit window_all(bit use_reset, bit v);
    int n;
    n = use_reset ? m_r_hist.size() : m_a_hist.size();
    if (n != D) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if ((use_reset ? m_r_hist[i] : m_a_hist[i]) != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  initial begin : model
    bit a_rise, a_fall, r_rise, r_fall;
    exp_t e;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_a_p0 = 0; m_a_p1 = 0; m_r_p0 = 0; m_r_p1 = 0;
        m_sw_p0 = '0; m_sw_p1 = '0;
        m_a_hist.delete(); m_r_hist.delete();
        m_a_lvl = 0; m_r_lvl = 0; m_op = '0; m_data = '0;
        exp_q.delete();
      end else begin
        cycle++;
        m_a_hist.push_back(m_a_p1);
        if (m_a_hist.size() > D) void'(m_a_hist.pop_front());
        m_r_hist.push_back(m_r_p1);
        if (m_r_hist.size() > D) void'(m_r_hist.pop_front());
        a_rise = !m_a_lvl && window_all(1'b0, 1'b1);
        a_fall =  m_a_lvl && window_all(1'b0, 1'b0);
        r_rise = !m_r_lvl && window_all(1'b1, 1'b1);
        r_fall =  m_r_lvl && window_all(1'b1, 1'b0);
        if (a_rise && !m_r_lvl && !r_rise) begin
          m_op   = m_sw_p1[11:8];
          m_data = m_sw_p1[7:0];
          e.due  = cycle + 1;
          e.op   = m_op;
          e.data = m_data;
          exp_q.push_back(e);
        end
        if (a_rise) m_a_lvl = 1'b1;
        if (a_fall) m_a_lvl = 1'b0;
        if (r_rise) m_r_lvl = 1'b1;
        if (r_fall) m_r_lvl = 1'b0;
        m_a_p1 = m_a_p0;  m_a_p0 = bus.btn_action_raw;
        m_r_p1 = m_r_p0;  m_r_p0 = bus.btn_reset_raw;
        m_sw_p1 = m_sw_p0; m_sw_p0 = bus.sw_raw;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("levels", {30'd0, bus.btn_level}, {30'd0, m_r_lvl, m_a_lvl});
        chk("alu_reset", {31'd0, bus.alu_reset}, {31'd0, m_r_lvl});
        chk("operands", {20'd0, bus.op_addr, bus.data_in}, {20'd0, m_op, m_data});
        if (bus.do_action) begin
          dut_pulses++;
          if (exp_q.size() == 0) begin
            chk("do_action_unexpected", 32'd1, 32'd0);
          end else begin
            chk("do_action_cycle", exp_q[0].due, cycle);
            chk("do_action_operands", {20'd0, bus.op_addr, bus.data_in},
                {20'd0, exp_q[0].op, exp_q[0].data});
            void'(exp_q.pop_front());
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
          chk("do_action_missing", 32'd0, 32'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic r, input logic [11:0] sw);
    bus.btn_action_raw = a;
    bus.btn_reset_raw  = r;
    bus.sw_raw         = sw;
  endtask

  // Pulses reset_n low for 1 ns starting offset_ns after the next rising edge.
  task automatic async_rst(input int offset_ns);
    @(posedge clk);
    #(offset_ns);
    reset_n = 1'b0;
    #0.5;
    chk("async_reset_clears",
        {16'd0, bus.do_action, bus.alu_reset, bus.op_addr, bus.data_in, bus.btn_level}, 32'd0);
    #0.5;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  int p0;

  initial begin : stim
    drive(1'b0, 1'b0, 12'h000);
    hold(3);
    chk("reset_state",
        {16'd0, bus.do_action, bus.alu_reset, bus.op_addr, bus.data_in, bus.btn_level}, 32'd0);
    reset_n = 1'b1;
    hold(5);

    // Clean press
    p0 = dut_pulses;
    drive(1'b0, 1'b0, 12'h3A5);
    hold(3);
    drive(1'b1, 1'b0, 12'h3A5);
    hold(6);
    #1 chk("t1_op_data", {20'd0, bus.op_addr, bus.data_in}, 32'h3A5);
    hold(14);
    drive(1'b0, 1'b0, 12'h3A5);
    hold(12);
    #1 chk("t1_pulses", dut_pulses - p0, 1);

    // Bounce
    p0 = dut_pulses;
    for (int i = 0; i < 8; i++) begin
      drive(i[0] ? 1'b0 : 1'b1, 1'b0, 12'h7C1);
      hold(1);
    end
    drive(1'b0, 1'b0, 12'h7C1);
    hold(12);
    #1 chk("t2_pulses", dut_pulses - p0, 0);

    // Hold and repeat, switches change mid-hold
    p0 = dut_pulses;
    drive(1'b1, 1'b0, 12'h512);
    hold(25);
    drive(1'b1, 1'b0, 12'hB3C);
    hold(25);
    drive(1'b0, 1'b0, 12'hB3C);
    hold(10);
    drive(1'b1, 1'b0, 12'hB3C);
    hold(10);
    drive(1'b0, 1'b0, 12'hB3C);
    hold(15);
    #1 chk("t3_pulses", dut_pulses - p0, 2);
    chk("t3_second_capture", {20'd0, bus.op_addr, bus.data_in}, 32'hB3C);

    // Reset priority on a simultaneous accept
    p0 = dut_pulses;
    drive(1'b1, 1'b1, 12'hE44);
    hold(8);
    #1 chk("t4_alu_reset", {31'd0, bus.alu_reset}, 32'd1);
    chk("t4_operands_held", {20'd0, bus.op_addr, bus.data_in}, 32'hB3C);
    hold(10);
    drive(1'b0, 1'b0, 12'hE44);
    hold(15);
    #1 chk("t4_pulses", dut_pulses - p0, 0);

    // Async reset at count 2, button held so it is re-accepted afterwards
    p0 = dut_pulses;
    drive(1'b1, 1'b0, 12'h4D2);
    hold(3);
    async_rst(2);
    hold(20);
    drive(1'b0, 1'b0, 12'h4D2);
    hold(12);
    #1 chk("t5_pulses", dut_pulses - p0, 1);

    // Async reset between capture and strobe drops the strobe
    p0 = dut_pulses;
    drive(1'b1, 1'b0, 12'h1F0);
    hold(5);
    async_rst(2);
    hold(20);
    drive(1'b0, 1'b0, 12'h1F0);
    hold(12);
    #1 chk("t5b_pulses", dut_pulses - p0, 1);

    // Short release is ignored
    p0 = dut_pulses;
    drive(1'b1, 1'b0, 12'h2A7);
    hold(12);
    drive(1'b0, 1'b0, 12'h2A7);
    hold(3);
    drive(1'b1, 1'b0, 12'h2A7);
    hold(3);
    #1 chk("t6_level_held", {31'd0, bus.btn_level[0]}, 32'd1);
    hold(10);
    drive(1'b0, 1'b0, 12'h2A7);
    hold(12);
    #1 chk("t6_pulses", dut_pulses - p0, 1);

    // Randomized traffic
    for (int s = 0; s < 300; s++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 12'($urandom));
      if ($urandom_range(0, 39) == 0) async_rst(int'($urandom_range(1, 8)));
      hold(int'($urandom_range(1, 10)));
    end
    drive(1'b0, 1'b0, 12'h000);
    hold(20);
    #1 chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
